// File: rtl/apb_req_arbiter_if.sv
// Requester-side and bridge-side signal bundle for apb_req_arbiter.
// master = arbiter view, slave = requesters/bridge view.
interface apb_req_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 9,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_rw;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_grant;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               transfer;
  logic               read_write;
  logic [AW-1:0]      apb_write_paddr;
  logic [AW-1:0]      apb_read_paddr;
  logic [DW-1:0]      apb_write_data;
  logic [DW-1:0]      apb_read_data_out;
  logic               xfer_done;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, apb_read_data_out, xfer_done,
    output req_grant, rsp_valid, rsp_rdata, rsp_err, transfer, read_write,
           apb_write_paddr, apb_read_paddr, apb_write_data
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, apb_read_data_out, xfer_done,
    input  req_grant, rsp_valid, rsp_rdata, rsp_err, transfer, read_write,
           apb_write_paddr, apb_read_paddr, apb_write_data
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin sequencer sharing one APB bridge command port among NREQ requesters.
// Optional BUSY watchdog enabled by defining APB_REQ_ARBITER_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int NREQ           = 2,
  parameter int AW             = 9,
  parameter int DW             = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  apb_req_arbiter_if.master bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d, winner;
  logic            found;
  logic [NREQ-1:0] grant_q, grant_d, rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic            err_q, err_d, transfer_q, transfer_d, rw_q, rw_d;
  logic [AW-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Search starts just after the last winner, wrapping at NREQ.
  always_comb begin : pick
    int idx;
    found  = 1'b0;
    winner = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  // NOTE: every variable gets its hold/default value first so no path can leave one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = '0;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    transfer_d  = transfer_q;
    rw_d        = rw_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    wdata_d     = wdata_q;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = NREQ'(1) << winner;
          transfer_d = 1'b1;
          rw_d       = bus.req_rw[winner];
          owner_d    = winner;
          ptr_d      = winner;
          state_d    = BUSY;
          if (bus.req_rw[winner]) begin
            raddr_d = bus.req_addr[winner*AW +: AW];
          end else begin
            waddr_d = bus.req_addr[winner*AW +: AW];
            wdata_d = bus.req_wdata[winner*DW +: DW];
          end
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      BUSY: begin
        if (bus.xfer_done) begin
          transfer_d  = 1'b0;
          rsp_valid_d = NREQ'(1) << owner_q;
          err_d       = 1'b0;
          state_d     = GAP;
          if (rw_q) rdata_d = bus.apb_read_data_out;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          transfer_d  = 1'b0;
          rsp_valid_d = NREQ'(1) << owner_q;
          err_d       = 1'b1;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(NREQ - 1);
      owner_q     <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      transfer_q  <= 1'b0;
      rw_q        <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      wdata_q     <= '0;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      transfer_q  <= transfer_d;
      rw_q        <= rw_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      wdata_q     <= wdata_d;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.req_grant       = grant_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rdata_q;
  assign bus.rsp_err         = err_q;
  assign bus.transfer        = transfer_q;
  assign bus.read_write      = rw_q;
  assign bus.apb_write_paddr = waddr_q;
  assign bus.apb_read_paddr  = raddr_q;
  assign bus.apb_write_data  = wdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter (NREQ=2, AW=9, DW=8).
// Timeout steps run only when APB_REQ_ARBITER_TIMEOUT_EN is defined.
module tb_apb_req_arbiter;
  logic pclk = 1'b0;
  logic preset;
  int   checks = 0;
  int   errors = 0;

  apb_req_arbiter_if #(.NREQ(2), .AW(9), .DW(8)) bus ();

  apb_req_arbiter #(.NREQ(2), .AW(9), .DW(8), .TIMEOUT_CYCLES(16)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus.master)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset                = 1'b1;
    bus.req_valid         = '0;
    bus.req_rw            = '0;
    bus.req_addr          = '0;
    bus.req_wdata         = '0;
    bus.apb_read_data_out = '0;
    bus.xfer_done         = 1'b0;
    repeat (3) tick();
    check("rst_transfer", 32'(bus.transfer), 32'd0);
    check("rst_grant", 32'(bus.req_grant), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_wpaddr", 32'(bus.apb_write_paddr), 32'd0);
    preset = 1'b0;
    tick();

    // Requester 0 write 0x005 <- 0xA5, done sampled 3 edges after transfer rises.
    bus.req_valid = 2'b01;
    bus.req_rw    = 2'b00;
    bus.req_addr  = {9'h000, 9'h005};
    bus.req_wdata = {8'h00, 8'hA5};
    tick();
    check("w_grant", 32'(bus.req_grant), 32'h1);
    check("w_transfer", 32'(bus.transfer), 32'd1);
    check("w_rw", 32'(bus.read_write), 32'd0);
    check("w_paddr", 32'(bus.apb_write_paddr), 32'h005);
    check("w_wdata", 32'(bus.apb_write_data), 32'hA5);
    bus.req_valid = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    tick();
    check("w_grant_pulse", 32'(bus.req_grant), 32'd0);
    check("w_hold_paddr", 32'(bus.apb_write_paddr), 32'h005);
    tick();
    check("w_busy_transfer", 32'(bus.transfer), 32'd1);
    bus.xfer_done = 1'b1;
    tick();
    check("w_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("w_done_transfer", 32'(bus.transfer), 32'd0);
    check("w_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("w_rdata_hold", 32'(bus.rsp_rdata), 32'd0);
    bus.xfer_done = 1'b0;
    tick();
    check("w_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

    // Requester 1 read 0x105, bridge returns 0x3C.
    bus.req_valid = 2'b10;
    bus.req_rw    = 2'b10;
    bus.req_addr  = {9'h105, 9'h000};
    tick();
    check("r_grant", 32'(bus.req_grant), 32'h2);
    check("r_rw", 32'(bus.read_write), 32'd1);
    check("r_paddr", 32'(bus.apb_read_paddr), 32'h105);
    check("r_wpaddr_hold", 32'(bus.apb_write_paddr), 32'h005);
    bus.req_valid         = 2'b00;
    bus.apb_read_data_out = 8'h3C;
    bus.xfer_done         = 1'b1;
    tick();
    check("r_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    check("r_rdata", 32'(bus.rsp_rdata), 32'h3C);
    check("r_done_transfer", 32'(bus.transfer), 32'd0);
    bus.xfer_done         = 1'b0;
    bus.apb_read_data_out = 8'hFF;
    tick();
    check("r_rdata_hold", 32'(bus.rsp_rdata), 32'h3C);

    // Stray xfer_done in IDLE must not produce a response.
    bus.xfer_done = 1'b1;
    tick();
    check("idle_done_ignored", 32'(bus.rsp_valid), 32'd0);
    bus.xfer_done = 1'b0;

    // Both requesters held: alternate 0,1,0,1 with two low transfer cycles between.
    bus.req_valid = 2'b11;
    bus.req_rw    = 2'b00;
    bus.req_addr  = {9'h111, 9'h010};
    bus.req_wdata = {8'h22, 8'h11};
    for (int g = 0; g < 4; g++) begin
      tick();
      check($sformatf("rr_grant%0d", g), 32'(bus.req_grant), (g % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr_paddr%0d", g), 32'(bus.apb_write_paddr), (g % 2 == 0) ? 32'h010 : 32'h111);
      tick();
      check($sformatf("rr_busy_nogrant%0d", g), 32'(bus.req_grant), 32'd0);
      bus.xfer_done = 1'b1;
      tick();
      check($sformatf("rr_rsp%0d", g), 32'(bus.rsp_valid), (g % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr_low1_%0d", g), 32'(bus.transfer), 32'd0);
      bus.xfer_done = 1'b0;
      tick();
      check($sformatf("rr_low2_%0d", g), 32'(bus.transfer), 32'd0);
      check($sformatf("rr_gap_nogrant%0d", g), 32'(bus.req_grant), 32'd0);
    end
    bus.req_valid = 2'b00;

    // Reset during BUSY drops transfer at once and never responds.
    bus.req_valid = 2'b10;
    bus.req_rw    = 2'b10;
    bus.req_addr  = {9'h0AA, 9'h000};
    tick();
    check("rb_grant", 32'(bus.req_grant), 32'h2);
    bus.req_valid = 2'b00;
    tick();
    #2;
    preset = 1'b1;
    #1;
    check("rb_async_transfer", 32'(bus.transfer), 32'd0);
    check("rb_async_rw", 32'(bus.read_write), 32'd0);
    check("rb_async_rdata", 32'(bus.rsp_rdata), 32'd0);
    bus.xfer_done = 1'b1;
    tick();
    tick();
    check("rb_no_rsp", 32'(bus.rsp_valid), 32'd0);
    preset        = 1'b0;
    bus.xfer_done = 1'b0;
    tick();
    check("rb_no_replay", 32'(bus.transfer), 32'd0);
    bus.req_valid = 2'b11;
    bus.req_rw    = 2'b01;
    bus.req_addr  = {9'h055, 9'h0C3};
    tick();
    check("rb_first_grant", 32'(bus.req_grant), 32'h1);
    check("rb_first_paddr", 32'(bus.apb_read_paddr), 32'h0C3);
    bus.req_valid         = 2'b00;
    bus.apb_read_data_out = 8'h5A;
    bus.xfer_done         = 1'b1;
    tick();
    check("rb_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("rb_rdata", 32'(bus.rsp_rdata), 32'h5A);
    bus.xfer_done = 1'b0;
    tick();

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    // Read with no xfer_done: timeout after 16 BUSY cycles, rdata untouched.
    bus.req_valid         = 2'b01;
    bus.req_rw            = 2'b01;
    bus.req_addr          = {9'h000, 9'h1F0};
    bus.apb_read_data_out = 8'hEE;
    tick();
    check("to_grant", 32'(bus.req_grant), 32'h1);
    bus.req_valid = 2'b00;
    for (int i = 1; i < 16; i++) tick();
    check("to_still_busy", 32'(bus.transfer), 32'd1);
    check("to_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("to_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("to_transfer", 32'(bus.transfer), 32'd0);
    check("to_rdata_hold", 32'(bus.rsp_rdata), 32'h5A);
    tick();
    // xfer_done on the timeout edge wins.
    bus.req_valid = 2'b01;
    bus.req_rw    = 2'b00;
    tick();
    check("to2_grant", 32'(bus.req_grant), 32'h1);
    bus.req_valid = 2'b00;
    for (int i = 1; i < 16; i++) tick();
    bus.xfer_done = 1'b1;
    tick();
    check("to2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("to2_rsp_err", 32'(bus.rsp_err), 32'd0);
    bus.xfer_done = 1'b0;
    tick();
`else
    check("no_to_rsp_err", 32'(bus.rsp_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the APB master bridge's command port (transfer / read_write / paddr / wdata) between NREQ requesters.
- Accepts one request at a time and holds the bridge command stable until the bridge signals completion. Returns read data and a one-hot completion pulse to the owning requester.
- Sits directly in front of the APB master bridge in the two-slave subsystem.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 9, address width; matches bridge paddr width.
- DW, 8, data width; matches bridge data width.
- TIMEOUT_CYCLES, 16, watchdog limit in BUSY cycles; used only with the optional feature.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; held until granted.
- req_rw  in  NREQ  per-requester direction: 1=read, 0=write.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- req_grant  out  NREQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DW  read data of last completed read.
- rsp_err  out  1  completion was a timeout (optional feature).
- transfer  out  1  command valid to bridge.
- read_write  out  1  to bridge: 1=read, 0=write.
- apb_write_paddr  out  AW  write address to bridge.
- apb_read_paddr  out  AW  read address to bridge.
- apb_write_data  out  DW  write data to bridge.
- apb_read_data_out  in  DW  read data from bridge; valid with xfer_done.
- xfer_done  in  1  bridge completion strobe for the current transfer.

Behaviour:
- One clock (pclk). preset is asynchronous and active-high.
- Reset values: all outputs 0; state=IDLE; rr pointer=NREQ-1, so requester 0 wins first.
- All outputs are registered.
- FSM IDLE: when any req_valid bit is set, select the winner by searching from pointer+1 modulo NREQ. At that edge:
  - req_grant<=onehot(winner); transfer<=1; read_write<=req_rw[w]; owner<=w; pointer<=w; state<=BUSY.
  - Read: apb_read_paddr<=addr. Write: apb_write_paddr<=addr and apb_write_data<=wdata.
  - Unselected bridge address/data registers hold their previous values.
- Grant latency: 1 cycle from sampled req_valid. req_grant is high for exactly 1 cycle. The requester may change or drop its inputs after the grant.
- FSM BUSY:
  - req_grant=0. transfer and all command outputs are held constant.
  - New req_valid is ignored; no grant is issued while BUSY.
  - On sampled xfer_done: transfer<=0; rsp_valid<=onehot(owner); if read, rsp_rdata<=apb_read_data_out (for writes, rsp_rdata holds); rsp_err<=0; state<=GAP.
- FSM GAP: one cycle with transfer low so the bridge returns to idle. rsp_valid clears. state<=IDLE.
  - Back-to-back transfers therefore have a minimum of 2 low cycles of transfer between them.
- xfer_done seen in IDLE or GAP: ignored.
- req_valid withdrawn before grant: allowed; not granted.
- Reset asserted mid-operation: transfer drops immediately (async); no rsp_valid is issued; the lost request is not replayed.
- NREQ=1: the pointer is a constant and arbitration is trivial.

Optional Feature:
- Macro: APB_REQ_ARBITER_TIMEOUT_EN.
- Defined:
  - A BUSY cycle counter clears on entering BUSY.
  - If TIMEOUT_CYCLES BUSY cycles elapse without xfer_done: transfer<=0, rsp_valid<=onehot(owner), rsp_err<=1, rsp_rdata unchanged, state<=GAP.
  - xfer_done on the same edge as the timeout: xfer_done wins, rsp_err=0.
- Undefined: no counter exists; BUSY waits indefinitely; rsp_err is tied 0.

Test Plan:
- Apply preset mid-simulation → all outputs 0 asynchronously; first grant after release goes to requester 0 when both request.
- Req0 write, addr 0x005, data 0xA5; xfer_done 3 cycles after transfer rises → req_grant=01 for 1 cycle, transfer=1, read_write=0, apb_write_paddr=0x005, apb_write_data=0xA5; then rsp_valid=01 for 1 cycle and transfer=0.
- Req1 read, addr 0x105; apb_read_data_out=0x3C with xfer_done → apb_read_paddr=0x105, read_write=1, rsp_valid=10, rsp_rdata=0x3C.
- Both requesters held valid continuously, xfer_done 2 cycles after each transfer rises → grant order 0,1,0,1 with exactly 2 low transfer cycles between commands.
- Assert preset during BUSY → transfer=0 the same cycle, no rsp_valid; after release, a fresh request completes normally.
- With APB_REQ_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no xfer_done → after 16 BUSY cycles rsp_valid=onehot(owner), rsp_err=1, transfer=0; repeat with xfer_done on cycle 16 → rsp_err=0.
